wb_port_arbiter: RTL
====================

# wb_port_arbiter

Shares the single scoreboard write-back port between the fixed-latency path and the variable-latency functional units (multiplier, divider, FPU, CV-X-IF) in the execute stage. The fixed-latency path cannot stall and always has priority. The other units are served round-robin through valid/ready handshakes. A starvation counter asks the issue stage to hold fixed-latency issue so that a waiting unit is eventually granted. Sits between the execute-stage units and the scoreboard write-back port; the output is registered.

## Interface
Parameters:
- NrReq, 4, number of stallable requesters (min 1, max 8)
- MaxWait, 8, cycles a valid requester may wait before an issue hold is asserted (min 1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- flush_i  in  1  pipeline flush
- fix_valid_i  in  1  fixed-latency result valid (no backpressure)
- fix_result_i  in  riscv::XLEN  fixed-latency result
- fix_trans_id_i  in  TRANS_ID_BITS  fixed-latency scoreboard ID
- fix_exception_i  in  exception_t  fixed-latency exception
- req_valid_i  in  NrReq  per-requester result valid
- req_ready_o  out  NrReq  per-requester grant; a transfer occurs when valid and ready are both high
- req_result_i  in  NrReq x riscv::XLEN  results
- req_trans_id_i  in  NrReq x TRANS_ID_BITS  IDs
- req_exception_i  in  NrReq x exception_t  exceptions
- wb_valid_o  out  1  registered write-back valid
- wb_result_o  out  riscv::XLEN  registered result
- wb_trans_id_o  out  TRANS_ID_BITS  registered ID
- wb_exception_o  out  exception_t  registered exception
- wb_src_o  out  WB_SRC_BITS  winner: 0 = fixed path, i+1 = requester i
- issue_hold_o  out  1  request to the issue stage: do not issue fixed-latency ops next cycle

## Operation
- Grant logic is combinational each cycle.
  - If fix_valid_i is high: the fixed path wins and req_ready_o = 0.
  - Otherwise: round-robin over req_valid_i, starting at pointer rr_q. At most one req_ready_o bit is high, and only on a valid requester.
- Round-robin pointer:
  - On a requester grant to index g, rr_q <= (g+1) mod NrReq.
  - Otherwise rr_q holds.
  - Fixed-path wins never move rr_q.
- Output register:
  - On any winner, it loads that winner's result, ID, exception and wb_src, and wb_valid_o <= 1.
  - If there is no winner, wb_valid_o <= 0. The data fields hold their value and do not matter.
  - Exceptions pass through unmodified, including the valid bit.
- Starvation control:
  - Per-requester counter wait_q[i], 0..MaxWait, saturating.
  - It increments when req_valid_i[i] is high and the requester is not granted.
  - It clears to 0 when the requester is granted or req_valid_i[i] is low.
  - issue_hold_o is registered: it is 1 in the cycle after any wait_q[i] reaches MaxWait, and stays 1 until that requester is granted.
  - The issue stage guarantees fix_valid_i = 0 while it honours the hold, so the round-robin must grant the starved unit within NrReq cycles.
- Flush:
  - While flush_i is high: req_ready_o = 0, wb_valid_o <= 0, all wait_q <= 0, issue_hold_o <= 0.
  - fix_valid_i is ignored during flush. rr_q is preserved.
- A requester must hold its data and valid stable until granted (standard valid/ready rule). It must not drop valid without a grant, except on flush.

## Timing
- Reset values: wb_valid_o = 0, wb_result_o = 0, wb_trans_id_o = 0, wb_exception_o = 0, wb_src_o = 0, issue_hold_o = 0, rr_q = 0, all wait_q = 0.
- req_ready_o is combinational and evaluates to 0 in the first cycle after reset unless a requester is valid.
- Latency:
  - Grant in cycle N gives wb_valid_o in cycle N+1. A sustained single requester gets one result per cycle.
  - wait_q reaching MaxWait in cycle N gives issue_hold_o in cycle N+1.
- Boundary conditions:
  - fix_valid_i together with all requesters valid: the fixed path wins and no counter clears.
  - Pointer wrap: after granting index NrReq-1, rr_q becomes 0.
  - Counters saturate at MaxWait and never wrap.
  - Flush in the same cycle as a grant: the flush wins; no ready is asserted and nothing is written.
  - Reset asserted mid-transfer: all state returns to reset values on the next edge.

## Structure
- ariane_pkg holds:
  - WB_SRC_BITS = $clog2(NrReq+1)
  - wb_req_t (result, trans_id, exception), shared by fix_* and req_*
- One sub-module, rr_arb_idx: a combinational round-robin priority picker.
  - Inputs: request vector, start pointer.
  - Outputs: one-hot grant and index.
- Everything else (output register, counters, hold flop) is in the top.

## Test plan
- NrReq=4, req_valid_i=4'b1111 held for 8 cycles, fix idle -> grants go 0,1,2,3,0,1,2,3; wb_src_o goes 1,2,3,4,… one cycle later.
- fix_valid_i=1 and req_valid_i=4'b0100 in the same cycle -> req_ready_o=0, wb_src_o=0 next cycle, rr_q unchanged.
- MaxWait=8, fix_valid_i=1 for 20 cycles and req_valid_i[2]=1 -> issue_hold_o rises 9 cycles after the request; once fix drops, requester 2 is granted and issue_hold_o falls the next cycle.
- flush_i pulse while req_valid_i=4'b0011 -> req_ready_o=0 that cycle, wb_valid_o=0 next cycle, counters 0, rr_q preserved.
- Result 0xDEADBEEF, trans_id 5, exception.valid=1 on requester 3 -> next-cycle wb_result_o=0xDEADBEEF, wb_trans_id_o=5, wb_exception_o.valid=1, wb_src_o=4.
- Reset asserted with issue_hold_o=1 and wb_valid_o=1 -> all outputs 0 after one edge; the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the scoreboard write-back arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned Xlen        = 32;
  localparam int unsigned TransIdBits = 3;

  typedef struct packed {
    logic [Xlen-1:0] cause;
    logic [Xlen-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [Xlen-1:0]        result;
    logic [TransIdBits-1:0] trans_id;
    exception_t             exception;
  } wb_req_t;

  // Width of wb_src: 0 is the fixed path, 1..nr_req are the stallable requesters.
  function automatic int unsigned wb_src_bits(int unsigned nr_req);
    return $clog2(nr_req + 1);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_arb_idx.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module wb_port_arbiter_rr_arb_idx #(
  parameter int unsigned NrReq = 4,
  parameter int unsigned IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic [NrReq-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [NrReq-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  always_comb begin
    logic [IdxW-1:0] sel;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sel     = '0;
    for (int unsigned k = 0; k < NrReq; k++) begin
      sel = IdxW'((32'(ptr_i) + k) % NrReq);
      if (!valid_o && req_i[sel]) begin
        valid_o    = 1'b1;
        gnt_o[sel] = 1'b1;
        idx_o      = sel;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the scoreboard write-back port between the fixed-latency path (always first)
// and round-robin stallable units, with a starvation hold towards the issue stage.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NrReq   = 4,
  parameter int unsigned MaxWait = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               fix_valid_i,
  input  logic [Xlen-1:0]                    fix_result_i,
  input  logic [TransIdBits-1:0]             fix_trans_id_i,
  input  exception_t                         fix_exception_i,
  input  logic [NrReq-1:0]                   req_valid_i,
  output logic [NrReq-1:0]                   req_ready_o,
  input  logic [NrReq-1:0][Xlen-1:0]         req_result_i,
  input  logic [NrReq-1:0][TransIdBits-1:0]  req_trans_id_i,
  input  exception_t [NrReq-1:0]             req_exception_i,
  output logic                               wb_valid_o,
  output logic [Xlen-1:0]                    wb_result_o,
  output logic [TransIdBits-1:0]             wb_trans_id_o,
  output exception_t                         wb_exception_o,
  output logic [wb_src_bits(NrReq)-1:0]      wb_src_o,
  output logic                               issue_hold_o
);

  localparam int unsigned SrcW = wb_src_bits(NrReq);
  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam int unsigned CntW = $clog2(MaxWait + 1);

  logic [IdxW-1:0]             rr_q, rr_d;
  logic [NrReq-1:0][CntW-1:0]  wait_q, wait_d;
  logic [NrReq-1:0]            starved;
  logic                        hold_q, hold_d;
  logic                        wb_valid_q, wb_valid_d;
  wb_req_t                     wb_q, wb_d;
  logic [SrcW-1:0]             wb_src_q, wb_src_d;

  logic [NrReq-1:0]            arb_gnt;
  logic [IdxW-1:0]             arb_idx;
  logic                        arb_valid;
  logic                        fix_win, req_win;

  wb_port_arbiter_rr_arb_idx #(
    .NrReq (NrReq),
    .IdxW  (IdxW)
  ) u_rr_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Flush suppresses both sources; the fixed path needs no ready since it cannot stall.
  assign fix_win     = fix_valid_i & ~flush_i;
  assign req_win     = arb_valid & ~fix_valid_i & ~flush_i;
  assign req_ready_o = req_win ? arb_gnt : '0;

  always_comb begin
    wb_valid_d = 1'b0;
    wb_d       = wb_q;
    wb_src_d   = wb_src_q;
    rr_d       = rr_q;
    if (fix_win) begin
      wb_valid_d         = 1'b1;
      wb_d.result        = fix_result_i;
      wb_d.trans_id      = fix_trans_id_i;
      wb_d.exception     = fix_exception_i;
      wb_src_d           = '0;
    end else if (req_win) begin
      wb_valid_d         = 1'b1;
      wb_d.result        = req_result_i[arb_idx];
      wb_d.trans_id      = req_trans_id_i[arb_idx];
      wb_d.exception     = req_exception_i[arb_idx];
      wb_src_d           = SrcW'(arb_idx) + SrcW'(1);
      rr_d               = (arb_idx == IdxW'(NrReq - 1)) ? '0 : arb_idx + IdxW'(1);
    end
  end

  for (genvar i = 0; i < NrReq; i++) begin : g_wait
    always_comb begin
      wait_d[i] = wait_q[i];
      if (flush_i || !req_valid_i[i] || req_ready_o[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != CntW'(MaxWait)) begin
        wait_d[i] = wait_q[i] + CntW'(1);
      end
    end
    // A saturated requester keeps the hold up until the cycle it is finally granted.
    assign starved[i] = (wait_q[i] == CntW'(MaxWait)) & ~req_ready_o[i];
  end

  assign hold_d = |starved & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      wait_q     <= '0;
      hold_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      wb_src_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      wait_q     <= wait_d;
      hold_q     <= hold_d;
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign wb_valid_o     = wb_valid_q;
  assign wb_result_o    = wb_q.result;
  assign wb_trans_id_o  = wb_q.trans_id;
  assign wb_exception_o = wb_q.exception;
  assign wb_src_o       = wb_src_q;
  assign issue_hold_o   = hold_q;

endmodule
